// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit operation codes and the op-select width.
package alu_pkg;

  localparam int OP_SEL_W = 3;

  localparam logic [OP_SEL_W-1:0] OP_AND  = 3'b111;
  localparam logic [OP_SEL_W-1:0] OP_OR   = 3'b110;
  localparam logic [OP_SEL_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_SEL_W-1:0] OP_NOT1 = 3'b000;
  localparam logic [OP_SEL_W-1:0] OP_NOT2 = 3'b001;
  localparam logic [OP_SEL_W-1:0] OP_NAND = 3'b010;
  localparam logic [OP_SEL_W-1:0] OP_NOR  = 3'b011;
  localparam logic [OP_SEL_W-1:0] OP_XNOR = 3'b101;

endpackage

// File: rtl/logic_core.sv
// Combinational bitwise logic unit: eight operations plus zero and parity flags.
module logic_core
  import alu_pkg::*;
#(
  parameter int OPD_LENGTH = 32
) (
  input  logic [OPD_LENGTH-1:0] opd1,
  input  logic [OPD_LENGTH-1:0] opd2,
  input  logic [OP_SEL_W-1:0]   alu_op_select,
  output logic [OPD_LENGTH-1:0] logic_result,
  output logic                  zero_flag,
  output logic                  parity_flag
);

  always_comb begin
    logic_result = '0;
    case (alu_op_select)
      OP_AND:  logic_result = opd1 & opd2;
      OP_OR:   logic_result = opd1 | opd2;
      OP_XOR:  logic_result = opd1 ^ opd2;
      OP_NOT1: logic_result = ~opd1;
      OP_NOT2: logic_result = ~opd2;
      OP_NAND: logic_result = ~(opd1 & opd2);
      OP_NOR:  logic_result = ~(opd1 | opd2);
      OP_XNOR: logic_result = ~(opd1 ^ opd2);
      default: logic_result = '0;
    endcase
  end

  assign zero_flag   = ~|logic_result;
  assign parity_flag = ^logic_result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logic unit: valid/ready stage chain around logic_core with a pass-through tag.
//
// Handshake: a beat moves across an interface on a rising edge where valid and ready are
// both 1; valid never depends on ready, payload is held stable while valid=1 and ready=0.
module logic_unit_pipe
  import alu_pkg::*;
#(
  parameter int OPD_LENGTH = 32,
  parameter int STAGES     = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPD_LENGTH-1:0] opd1,
  input  logic [OPD_LENGTH-1:0] opd2,
  input  logic [OP_SEL_W-1:0]   alu_op_select,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPD_LENGTH-1:0] logic_result,
  output logic                  zero_flag,
  output logic                  parity_flag,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  // Per-stage views: index 0 is the core output fed by the operand registers.
  logic [STAGES-1:0]     v_s;
  logic [STAGES-1:0]     adv;
  logic [OPD_LENGTH-1:0] res_s [STAGES];
  logic [STAGES-1:0]     zf_s;
  logic [STAGES-1:0]     pf_s;
  logic [TAG_WIDTH-1:0]  tag_s [STAGES];

  // A stage advances when empty or when its downstream neighbour advances.
  always_comb begin
    logic down_ready;
    down_ready = out_ready;
    adv        = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]     = ~v_s[k] | down_ready;
      down_ready = adv[k];
    end
  end

  assign in_ready = adv[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_operand
      logic                  v_q,    v_d;
      logic [OPD_LENGTH-1:0] opd1_q, opd1_d;
      logic [OPD_LENGTH-1:0] opd2_q, opd2_d;
      logic [OP_SEL_W-1:0]   op_q,   op_d;
      logic [TAG_WIDTH-1:0]  tag_q,  tag_d;
      logic [OPD_LENGTH-1:0] core_res;
      logic                  core_zf;
      logic                  core_pf;

      always_comb begin
        v_d    = v_q;
        opd1_d = opd1_q;
        opd2_d = opd2_q;
        op_d   = op_q;
        tag_d  = tag_q;
        if (adv[0]) begin
          v_d = in_valid;
          if (in_valid) begin
            opd1_d = opd1;
            opd2_d = opd2;
            op_d   = alu_op_select;
            tag_d  = in_tag;
          end
        end
      end

      // AND of cleared operands yields result 0 with zero flag set, even when STAGES=1.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q    <= 1'b0;
          opd1_q <= '0;
          opd2_q <= '0;
          op_q   <= OP_AND;
          tag_q  <= '0;
        end else begin
          v_q    <= v_d;
          opd1_q <= opd1_d;
          opd2_q <= opd2_d;
          op_q   <= op_d;
          tag_q  <= tag_d;
        end
      end

      logic_core #(
        .OPD_LENGTH(OPD_LENGTH)
      ) u_core (
        .opd1         (opd1_q),
        .opd2         (opd2_q),
        .alu_op_select(op_q),
        .logic_result (core_res),
        .zero_flag    (core_zf),
        .parity_flag  (core_pf)
      );

      assign v_s[0]   = v_q;
      assign res_s[0] = core_res;
      assign zf_s[0]  = core_zf;
      assign pf_s[0]  = core_pf;
      assign tag_s[0] = tag_q;
    end else begin : g_result
      logic                  v_q,   v_d;
      logic [OPD_LENGTH-1:0] res_q, res_d;
      logic                  zf_q,  zf_d;
      logic                  pf_q,  pf_d;
      logic [TAG_WIDTH-1:0]  tag_q, tag_d;

      always_comb begin
        v_d   = v_q;
        res_d = res_q;
        zf_d  = zf_q;
        pf_d  = pf_q;
        tag_d = tag_q;
        if (adv[g]) begin
          v_d = v_s[g-1];
          if (v_s[g-1]) begin
            res_d = res_s[g-1];
            zf_d  = zf_s[g-1];
            pf_d  = pf_s[g-1];
            tag_d = tag_s[g-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          res_q <= '0;
          zf_q  <= 1'b1;
          pf_q  <= 1'b0;
          tag_q <= '0;
        end else begin
          v_q   <= v_d;
          res_q <= res_d;
          zf_q  <= zf_d;
          pf_q  <= pf_d;
          tag_q <= tag_d;
        end
      end

      assign v_s[g]   = v_q;
      assign res_s[g] = res_q;
      assign zf_s[g]  = zf_q;
      assign pf_s[g]  = pf_q;
      assign tag_s[g] = tag_q;
    end
  end

  assign out_valid    = v_s[STAGES-1];
  assign logic_result = res_s[STAGES-1];
  assign zero_flag    = zf_s[STAGES-1];
  assign parity_flag  = pf_s[STAGES-1];
  assign out_tag      = tag_s[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: directed streams on an 8-bit/2-stage instance plus a
// parameter sweep, checked by queue-based scoreboards with monitors on the output side.
module tb_logic_unit_pipe;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // ---------------- main DUT (8 bit, 2 stages) ----------------
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] opd1, opd2, logic_result;
  logic [2:0] op;
  logic [3:0] in_tag, out_tag;
  logic       zero_flag, parity_flag;

  logic_unit_pipe #(
    .OPD_LENGTH(8),
    .STAGES    (2),
    .TAG_WIDTH (4)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opd1         (opd1),
    .opd2         (opd2),
    .alu_op_select(op),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .logic_result (logic_result),
    .zero_flag    (zero_flag),
    .parity_flag  (parity_flag),
    .out_tag      (out_tag)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0, n_fail = 0;
  int n_acc = 0, n_ret = 0, n_both = 0;
  bit tog = 1'b0;
  bit sweep_go = 1'b0;
  wire [2:0] sw_done;
  logic [13:0] exp_q[$];  // {result[7:0], zero, parity, tag[3:0]}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the logic unit, 32 bits wide, masked per instance width.
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    case (o)
      3'b111:  return a & b;
      3'b110:  return a | b;
      3'b100:  return a ^ b;
      3'b000:  return ~a;
      3'b001:  return ~b;
      3'b010:  return ~(a & b);
      3'b011:  return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic [31:0] wmask(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                      input logic [3:0] t, input logic [7:0] er, input logic ez,
                      input logic ep);
    bit acc = 1'b0;
    int guard = 0;
    opd1 = a; opd2 = b; op = o; in_tag = t; in_valid = 1'b1;
    while (!acc && guard < 100) begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        exp_q.push_back({er, ez, ep, t});
        n_acc++;
        acc = 1'b1;
      end
      tick();
      if (tog) out_ready = ~out_ready;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_accept_timeout", acc, 1);
  endtask

  task automatic send_m(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                        input logic [3:0] t);
    logic [31:0] r;
    r = ref_op(o, {24'b0, a}, {24'b0, b}) & wmask(8);
    send(a, b, o, t, r[7:0], (r == 32'd0), ^r);
  endtask

  task automatic drain(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      tick();
      g++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [13:0] e;
    if (rst_n && out_valid && out_ready) begin
      n_ret++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got tag %0h result %0h, required no beat",
                 out_tag, logic_result);
      end else begin
        e = exp_q.pop_front();
        chk("result", logic_result, e[13:6]);
        chk("zero_flag", zero_flag, e[5]);
        chk("parity_flag", parity_flag, e[4]);
        chk("out_tag", out_tag, e[3:0]);
      end
    end
    if (rst_n && in_valid && in_ready && out_valid && out_ready) n_both++;
  end

  // ---------------- parameter sweep instances ----------------
  logic [31:0] sw_a [8] = '{32'hcccc_cccc, 32'h0000_000e, 32'hffff_ffff, 32'h1234_5678,
                            32'h8000_0001, 32'h0000_0000, 32'hdead_beef, 32'h5555_aaaa};
  logic [31:0] sw_b [8] = '{32'hffff_ffff, 32'h0000_00a0, 32'h0000_0000, 32'h8765_4321,
                            32'h8000_0001, 32'h0000_0000, 32'h0f0f_f0f0, 32'haaaa_5555};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int SW = (gi == 1) ? 1 : 32;
    localparam int SS = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zf, s_pf;
    logic [SW-1:0] s_opd1, s_opd2, s_res;
    logic [2:0]    s_op;
    logic [3:0]    s_tag_i, s_tag_o;
    logic          done;
    logic [37:0]   sq[$];  // {result[31:0], zero, parity, tag[3:0]}
    int            lat_q[$];

    assign s_out_ready = 1'b1;
    assign sw_done[gi] = done;

    logic_unit_pipe #(
      .OPD_LENGTH(SW),
      .STAGES    (SS),
      .TAG_WIDTH (4)
    ) u_sw (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (s_in_valid),
      .in_ready     (s_in_ready),
      .opd1         (s_opd1),
      .opd2         (s_opd2),
      .alu_op_select(s_op),
      .in_tag       (s_tag_i),
      .out_valid    (s_out_valid),
      .out_ready    (s_out_ready),
      .logic_result (s_res),
      .zero_flag    (s_zf),
      .parity_flag  (s_pf),
      .out_tag      (s_tag_o)
    );

    initial begin : drv
      int g;
      bit acc;
      logic [31:0] r, a, b;
      done = 1'b0; s_in_valid = 1'b0; s_opd1 = '0; s_opd2 = '0; s_op = '0; s_tag_i = '0;
      wait (sweep_go);
      tick();
      for (int k = 0; k < 8; k++) begin
        a = sw_a[k];
        b = sw_b[k];
        s_opd1 = a[SW-1:0]; s_opd2 = b[SW-1:0]; s_op = 3'(k); s_tag_i = 4'(k);
        s_in_valid = 1'b1;
        acc = 1'b0; g = 0;
        while (!acc && g < 50) begin
          @(negedge clk);
          if (s_in_ready && rst_n) begin
            r = ref_op(3'(k), a, b) & wmask(SW);
            sq.push_back({r, (r == 32'd0), ^r, 4'(k)});
            lat_q.push_back(cyc + 1);
            acc = 1'b1;
          end
          tick();
          g++;
        end
        chk($sformatf("sw%0d_accept", gi), acc, 1);
      end
      s_in_valid = 1'b0;
      g = 0;
      while (sq.size() != 0 && g < 40) begin
        tick();
        g++;
      end
      chk($sformatf("sw%0d_drained", gi), sq.size(), 0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      logic [37:0] e;
      int lat;
      if (rst_n && s_out_valid && s_out_ready) begin
        if (sq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sw%0d_unexpected_beat: got tag %0h, required no beat", gi, s_tag_o);
        end else begin
          e = sq.pop_front();
          lat = lat_q.pop_front();
          chk($sformatf("sw%0d_result", gi), 32'(s_res), e[37:6]);
          chk($sformatf("sw%0d_zero", gi), s_zf, e[5]);
          chk($sformatf("sw%0d_parity", gi), s_pf, e[4]);
          chk($sformatf("sw%0d_tag", gi), s_tag_o, e[3:0]);
          chk($sformatf("sw%0d_latency", gi), cyc - lat, SS - 1);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [2:0] ops_tab [8] = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
  logic [7:0] res_tab [8] = '{8'hcc, 8'hff, 8'h33, 8'h33, 8'h00, 8'h33, 8'h00, 8'hcc};
  logic       zf_tab  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin : main_seq
    int c0, a0, r0, b0, g;
    logic [13:0] snap;
    rst_n = 1'b0; in_valid = 1'b0; opd1 = '0; opd2 = '0; op = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state in the first cycle after release.
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", logic_result, 8'h00);
    chk("rst_zero_flag", zero_flag, 1);
    chk("rst_parity_flag", parity_flag, 0);
    chk("rst_out_tag", out_tag, 4'h0);
    tick();

    // All eight codes back-to-back, one beat per cycle.
    c0 = cyc;
    for (int k = 0; k < 8; k++)
      send(8'hcc, 8'hff, ops_tab[k], 4'(k), res_tab[k], zf_tab[k], 1'b0);
    chk("basic_throughput_cycles", cyc - c0, 8);
    drain("basic_drain");

    // Flag corner cases.
    send(8'h0e, 8'ha0, 3'b111, 4'h8, 8'h00, 1'b1, 1'b0);
    send(8'h0e, 8'ha0, 3'b100, 4'h9, 8'hae, 1'b0, 1'b1);
    drain("flags_drain");

    // Back-pressure: output stalled for five cycles while streaming.
    out_ready = 1'b0;
    a0 = n_acc;
    fork
      begin
        send(8'hf0, 8'h3c, 3'b111, 4'ha, 8'h30, 1'b0, 1'b0);
        send(8'hf0, 8'h3c, 3'b110, 4'hb, 8'hfc, 1'b0, 1'b0);
        send(8'hf0, 8'h3c, 3'b100, 4'hc, 8'hcc, 1'b0, 1'b0);
        send(8'hf0, 8'h3c, 3'b010, 4'hd, 8'hcf, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        snap = {logic_result, zero_flag, parity_flag, out_tag};
        chk("bp_head_valid", out_valid, 1);
        chk("bp_head_tag", out_tag, 4'ha);
        repeat (2) @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_accepted", n_acc - a0, 2);
        chk("bp_out_valid_held", out_valid, 1);
        chk("bp_payload_stable", {logic_result, zero_flag, parity_flag, out_tag}, snap);
        tick();
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Simultaneous push and pop: fill, then toggle out_ready every cycle.
    a0 = n_acc; r0 = n_ret; b0 = n_both;
    out_ready = 1'b0;
    send_m(8'h11, 8'h5a, 3'b100, 4'h0);
    send_m(8'h22, 8'h5a, 3'b101, 4'h1);
    tog = 1'b1;
    for (int k = 2; k < 12; k++)
      send_m(8'(k * 37), 8'h5a, 3'(k), 4'(k));
    tog = 1'b0;
    out_ready = 1'b1;
    drain("pp_drain");
    chk("pp_accepted", n_acc - a0, 12);
    chk("pp_retired", n_ret - r0, 12);
    chk("pp_simultaneous_seen", (n_both - b0) > 0, 1);

    // Mid-stream reset with two beats in flight and a beat offered during reset.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'b110, 4'h1, 8'h36, 1'b0, 1'b0);
    send(8'h12, 8'h34, 3'b111, 4'h2, 8'h10, 1'b0, 1'b1);
    rst_n = 1'b0;
    opd1 = 8'h77; opd2 = 8'h00; op = 3'b110; in_tag = 4'hf; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_result", logic_result, 8'h00);
    chk("mrst_zero_flag", zero_flag, 1);
    chk("mrst_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b1;
    r0 = n_ret;
    repeat (6) tick();
    chk("mrst_no_discarded_beats", n_ret - r0, 0);

    // Parameter sweep.
    sweep_go = 1'b1;
    g = 0;
    while (sw_done != 3'b111 && g < 400) begin
      tick();
      g++;
    end
    chk("sweep_done", sw_done, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
